// File: rtl/asmi_readback.sv
// Streams num_blocks 256-byte flash pages from the ASMI core into the Tx FIFO,
// bit-reversing every byte and keeping a 16-bit running checksum.
module asmi_readback #(
  parameter logic [23:0] BASE_ADDR  = 24'h100000,
  parameter logic [10:0] FIFO_LIMIT = 11'd1792,
  parameter logic [15:0] WDOG       = 16'd65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_req,
  input  logic [13:0] num_blocks,
  output logic        read_ACK,
  input  logic [10:0] IF_Tx_used,
  output logic        wrreq,
  output logic [7:0]  Tx_data,
  output logic [23:0] asmi_addr,
  output logic        asmi_rden,
  output logic        asmi_read,
  input  logic [7:0]  asmi_dataout,
  input  logic        asmi_data_valid,
  input  logic        asmi_busy,
  output logic        page_ready,
  input  logic        page_ready_ACK,
  output logic        read_done,
  output logic        timeout_err,
  output logic [15:0] checksum
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ROOM, S_ISSUE, S_STREAM,
    S_PAGE_END, S_WAIT_ACK, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] blocks_q, blocks_d;
  logic [13:0] page_q, page_d;
  logic [8:0]  byte_q, byte_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] wd_q, wd_d;
  logic        wrreq_q, wrreq_d;
  logic [7:0]  tx_q, tx_d;
  logic        page_ready_q, page_ready_d;

  logic [7:0]  rev;
  logic        accept;
  logic        watching;
  logic        wd_expire;

  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      rev[i] = asmi_dataout[7-i];
    end
  end

  assign accept    = (state_q == S_STREAM) && asmi_data_valid && !byte_q[8];
  assign watching  = (state_q == S_ISSUE) || (state_q == S_STREAM) ||
                     ((state_q == S_ROOM) && asmi_busy);
  // Fire on the idle cycle that would bring the counter to WDOG.
  assign wd_expire = watching && !asmi_data_valid && (wd_q == WDOG - 16'd1);

  always_comb begin
    state_d      = state_q;
    blocks_d     = blocks_q;
    page_d       = page_q;
    byte_d       = byte_q;
    addr_d       = addr_q;
    csum_d       = csum_q;
    wrreq_d      = 1'b0;
    tx_d         = tx_q;
    page_ready_d = page_ready_q;

    unique case (state_q)
      S_IDLE: begin
        page_ready_d = 1'b0;
        if (read_req && !asmi_busy) state_d = S_START;
      end
      S_START: begin
        blocks_d = num_blocks;
        page_d   = '0;
        csum_d   = '0;
        addr_d   = BASE_ADDR;
        state_d  = (num_blocks == '0) ? S_DONE : S_ROOM;
      end
      S_ROOM: begin
        if ((IF_Tx_used <= FIFO_LIMIT) && !asmi_busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        byte_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          wrreq_d = 1'b1;
          tx_d    = rev;
          csum_d  = csum_q + {8'd0, rev};
          byte_d  = byte_q + 9'd1;
          if (byte_q == 9'd255) state_d = S_PAGE_END;
        end
      end
      S_PAGE_END: begin
        page_d       = page_q + 14'd1;
        addr_d       = addr_q + 24'd256;
        page_ready_d = 1'b1;
        state_d      = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (page_ready_ACK) begin
          page_ready_d = 1'b0;
          state_d      = (page_q == blocks_q) ? S_DONE : S_ROOM;
        end
      end
      S_DONE, S_ERROR: begin
        if (!read_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wd_expire) state_d = S_ERROR;
  end

  always_comb begin
    if ((state_d != state_q) || asmi_data_valid) wd_d = '0;
    else if (watching)                           wd_d = wd_q + 16'd1;
    else                                         wd_d = wd_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      blocks_q     <= '0;
      page_q       <= '0;
      byte_q       <= '0;
      addr_q       <= BASE_ADDR;
      csum_q       <= '0;
      wd_q         <= '0;
      wrreq_q      <= 1'b0;
      tx_q         <= '0;
      page_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blocks_q     <= blocks_d;
      page_q       <= page_d;
      byte_q       <= byte_d;
      addr_q       <= addr_d;
      csum_q       <= csum_d;
      wd_q         <= wd_d;
      wrreq_q      <= wrreq_d;
      tx_q         <= tx_d;
      page_ready_q <= page_ready_d;
    end
  end

  assign read_ACK    = (state_q == S_START);
  assign asmi_read   = (state_q == S_ISSUE);
  assign asmi_rden   = (state_q == S_ISSUE) || (state_q == S_STREAM);
  assign read_done   = (state_q == S_DONE);
  assign timeout_err = (state_q == S_ERROR);
  assign wrreq       = wrreq_q;
  assign Tx_data     = tx_q;
  assign asmi_addr   = addr_q;
  assign page_ready  = page_ready_q;
  assign checksum    = csum_q;

endmodule

// File: doc/asmi_readback.md
ASMI_READBACK -- requirements
Module: asmi_readback

Interface
REQ-001 Parameter BASE_ADDR, default 24'h100000, is the flash byte address of page 0 (top 1MB image area).
REQ-002 Parameter FIFO_LIMIT, default 11'd1792, is the highest IF_Tx_used value at which a new 256-byte page may start.
REQ-003 Parameter WDOG, default 16'd65535, is the maximum number of idle cycles allowed between flash events before an error is declared.
REQ-004 clock  in  1  sole clock; all logic on the positive edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 read_req  in  1  level request from the PC-command decoder to start a readback.
REQ-007 num_blocks  in  14  number of 256-byte pages to read, sampled when a request is accepted.
REQ-008 read_ACK  out  1  high while a request is being accepted (state START).
REQ-009 IF_Tx_used  in  11  fill level of the Tx FIFO.
REQ-010 wrreq  out  1  Tx FIFO write strobe, one byte per high cycle.
REQ-011 Tx_data  out  8  byte to the Tx FIFO, in PC bit order.
REQ-012 asmi_addr  out  24  flash read address.
REQ-013 asmi_rden  out  1  ASMI read enable.
REQ-014 asmi_read  out  1  ASMI read-start strobe.
REQ-015 asmi_dataout  in  8  ASMI read data, in flash bit order.
REQ-016 asmi_data_valid  in  1  asmi_dataout holds a valid byte this cycle.
REQ-017 asmi_busy  in  1  ASMI operation in progress.
REQ-018 page_ready  out  1  a full page has been queued to the Tx FIFO.
REQ-019 page_ready_ACK  in  1  Tx side has seen page_ready.
REQ-020 read_done  out  1  all pages have been read.
REQ-021 timeout_err  out  1  the flash stalled and the readback was aborted.
REQ-022 checksum  out  16  running sum of all bytes read.

Function
REQ-023 States: IDLE, START, ROOM, ISSUE, STREAM, PAGE_END, WAIT_ACK, DONE, ERROR.
REQ-024 IDLE: hold read_done=0, timeout_err=0 and page_ready=0; on read_req=1 with asmi_busy=0, go to START.
REQ-025 START, exactly 1 cycle:
- read_ACK=1;
- latch num_blocks;
- clear page counter and checksum to 0;
- set asmi_addr=BASE_ADDR;
- go to ROOM, or to DONE if the latched num_blocks=0.
REQ-026 ROOM: wait until IF_Tx_used <= FIFO_LIMIT and asmi_busy=0, then go to ISSUE; this guarantees a whole page always fits, so no overflow can occur mid-page.
REQ-027 ISSUE, exactly 1 cycle: asmi_read=1 and asmi_rden=1; clear the byte counter (9 bits); go to STREAM.
REQ-028 STREAM, per cycle with asmi_data_valid=1:
- wrreq=1 on the next cycle;
- Tx_data = bit-reverse of asmi_dataout (bit0<->bit7, etc.);
- checksum += zero-extended Tx_data, modulo 2^16;
- byte counter +1.
REQ-029 STREAM: asmi_rden stays 1 until the 256th valid byte is accepted, then drops to 0 in the same cycle the counter reaches 256; the state then goes to PAGE_END.
REQ-030 Any asmi_data_valid arriving outside STREAM, or after 256 bytes, SHALL be ignored (no wrreq, no checksum change).
REQ-031 PAGE_END: page counter +1; asmi_addr += 256; page_ready=1; go to WAIT_ACK.
REQ-032 WAIT_ACK: clear page_ready on page_ready_ACK=1; then go to DONE if page counter = latched num_blocks, else go to ROOM.
REQ-033 DONE: read_done=1, held until read_req=0, then go to IDLE.
REQ-034 Watchdog: a 16-bit counter clears on every state change and on every asmi_data_valid, and increments otherwise while in ISSUE, STREAM or ROOM(asmi_busy=1). When it reaches WDOG:
- go to ERROR;
- asmi_rden=0;
- timeout_err=1.
REQ-035 ERROR: hold timeout_err=1 until read_req=0, then go to IDLE.
REQ-036 read_req deasserted mid-transfer SHALL NOT abort the transfer; only reset or a timeout aborts.
REQ-037 If page_ready_ACK and the last-page condition occur together, page_ready is cleared and DONE is entered in the same transition.
REQ-038 Address arithmetic wraps modulo 2^24; no range check.

Reset
REQ-039 On reset=1, at any time and in any state, all outputs SHALL go to 0, asmi_addr to BASE_ADDR, all counters to 0, and the state to IDLE; an in-flight page is discarded.

Verification
REQ-040 num_blocks=2, flash model returns bytes 8'h01..8'h00 per page, IF_Tx_used=0 -> 512 wrreq pulses, addresses 24'h100000 then 24'h100100, Tx_data bit-reversed, page_ready twice, read_done=1, checksum = sum of reversed bytes modulo 2^16.
REQ-041 IF_Tx_used=1800 before page 2 -> ISSUE withheld until IF_Tx_used drops to 1792; no wrreq while waiting.
REQ-042 Flash stops asserting data_valid after 100 bytes -> timeout_err=1 after exactly WDOG idle cycles, asmi_rden=0, no further wrreq.
REQ-043 reset asserted in STREAM at byte 57 -> all outputs 0 asynchronously; a new read_req then starts again at 24'h100000 with checksum=0.
REQ-044 num_blocks=0 -> read_ACK for one cycle, no asmi_read, read_done=1, checksum=0.
